muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide execution unit for the RV32M extension. It sits directly downstream of the register file: it takes the two read operands (RD1/RD2), computes over a fixed 32-cycle iteration, and returns a 32-bit result plus destination index for the register-file write port (WD3/A3/WE3). While the unit is computing, it stalls the core through `busy`.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `ITER`, default 32: iteration count. Must equal `XLEN`.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: **asynchronous, active-low reset**.
- `start` in 1: request, sampled only in IDLE.
- `funct3` in 3: operation select. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a` in 32: rs1 value (RD1).
- `op_b` in 32: rs2 value (RD2).
- `rd_in` in 5: destination register index.
- `busy` out 1: high from the accept edge until the unit returns to IDLE. Drives the PC/pipeline stall.
- `done` out 1: one-cycle pulse; `result` is valid during it.
- `result` out 32: final value. Held until the next accept.
- `rd_out` out 5: latched `rd_in`.
- `we_out` out 1: equals `done & (rd_out != 0)`. Drives the register file WE3.

## Operation
- FSM states are IDLE, RUN, DONE.
  - IDLE→RUN: `start`=1 at a rising edge. At that edge, latch `funct3`, `rd_in`, operand magnitudes, sign flags and zero/overflow flags, and clear the counter to 0.
  - RUN→RUN: each edge performs one iteration and increments the counter.
  - RUN→DONE: on the edge that completes iteration `ITER`-1. At the same edge, apply sign fix-up and special cases, then register `result`.
  - DONE→IDLE: unconditionally, on the next edge.
- Multiply: shift-add over a 64-bit accumulator on unsigned magnitudes.
  - Negate the 64-bit product if the operand signs differ.
  - Signedness: MUL and MULH treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
  - MUL returns bits [31:0]; the others return bits [63:32].
- Divide: restoring division, one quotient bit per cycle, on magnitudes.
  - Signed ops only: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- Special cases override the computed value. The latency stays fixed.
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `op_a`.
  - DIV with 0x80000000 / 0xFFFFFFFF: returns 0x80000000; REM returns 0.
- `start` outside IDLE is ignored. No queueing.
- Operands are captured at accept; later changes on `op_a`/`op_b` have no effect.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `we_out` 0, `result` 0, `rd_out` 0, counter 0. Reset mid-RUN aborts the operation and no `done` is produced.
- Latency: accept at edge E0. `done` is high in the cycle after E32, and IDLE resumes at E33. A new `start` can be accepted at E33.
- `busy` is high from after E0 through the DONE cycle, inclusive: 33 cycles.
- `busy` is registered; the core must combine it with its own decode (`start & ~busy`) to stall in the accept cycle.
- A result for x0 produces `done` but `we_out`=0.

## Structure
- Shared package `riscv_m_pkg` holds:
  - the funct3 localparams `F3_MUL` … `F3_REMU`;
  - the FSM state encoding `ST_IDLE`/`ST_RUN`/`ST_DONE`;
  - the constants `INT_MIN`=0x80000000 and `ALL_ONES`.
- Single module containing the FSM, a 6-bit counter, a 64-bit accumulator/remainder register, a 32-bit operand shift register and a sign-flag register. No sub-module is needed; a combinational 2's-complement helper function is sufficient.

## Test plan
- MUL: 7 × 6 → `result` 42, `done` at cycle 33 after accept; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULH: 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Divide by zero: DIVU 0x1234 / 0 → 0xFFFFFFFF; REM 0x1234 / 0 → 0x1234. Overflow: DIV 0x80000000 / -1 → 0x80000000, REM → 0.
- `start` pulsed in RUN with different operands → ignored, first result unchanged. Operands changed after accept → no effect.
- `rst` low at iteration 10 → `busy`/`done`/`result` are 0 immediately. After release, a fresh MUL 3 × 5 → 15 with full latency. `rd_in`=0 → `done`=1, `we_out`=0.

Source files
------------

// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 encodings, FSM state encoding, constants,
// and a two's-complement helper used by the multiply/divide unit.
package riscv_m_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, fixed 32-iteration latency, sign fix-up at the end.
module muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out,
  output state_t          dbg_state
);

  // Handshake: a request is taken on any rising edge where start=1 and the
  // unit is idle (busy=0); start while busy is dropped, never queued. The
  // result is valid only in the single cycle done=1.

  state_t            state, state_nxt;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc, acc_step;
  logic [XLEN-1:0]   opnd;
  logic              sign_a, sign_b;
  logic              div_zero, div_ovf;
  logic [2:0]        f3;
  logic              last;

  logic              a_sgn_in, b_sgn_in, zero_in, ovf_in;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;

  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_step, div_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, quo_s, rem_s, result_fix;

  // Operand conditioning at accept time
  always_comb begin
    a_sgn_in = (funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) & op_a[XLEN-1];
    b_sgn_in = (funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM}) & op_b[XLEN-1];
    mag_a_in = a_sgn_in ? neg32(op_a) : op_a;
    mag_b_in = b_sgn_in ? neg32(op_b) : op_b;
    zero_in  = (op_b == '0);
    ovf_in   = (funct3 inside {F3_DIV, F3_REM}) && (op_a == INT_MIN) && (op_b == ALL_ONES);
  end

  // One iteration of either algorithm; acc holds {hi, lo} in both cases
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_step  = {mul_sum, acc[XLEN-1:1]};
    div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    div_step  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_step  = f3[2] ? div_step : mul_step;
  end

  // Sign fix-up and special cases, applied to the final iteration's value.
  // A zero divisor leaves the dividend magnitude in the remainder, so the
  // signed remainder already equals op_a.
  always_comb begin
    prod  = (sign_a ^ sign_b) ? neg64(acc_step) : acc_step;
    quo   = acc_step[XLEN-1:0];
    rem   = acc_step[2*XLEN-1:XLEN];
    quo_s = (sign_a ^ sign_b) ? neg32(quo) : quo;
    rem_s = sign_a ? neg32(rem) : rem;
    result_fix = '0;
    case (f3)
      F3_MUL:                      result_fix = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_fix = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (div_zero)     result_fix = ALL_ONES;
        else if (div_ovf) result_fix = INT_MIN;
        else              result_fix = quo_s;
      end
      default: begin
        if (div_zero)     result_fix = rem_s;
        else if (div_ovf) result_fix = '0;
        else              result_fix = rem_s;
      end
    endcase
  end

  assign last = (cnt == 6'(ITER - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      f3       <= '0;
      rd_out   <= '0;
      result   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (start) begin
          f3       <= funct3;
          rd_out   <= rd_in;
          sign_a   <= a_sgn_in;
          sign_b   <= b_sgn_in;
          div_zero <= zero_in;
          div_ovf  <= ovf_in;
          cnt      <= '0;
          // Divide shifts the dividend through acc; multiply shifts the multiplier
          acc      <= funct3[2] ? {{XLEN{1'b0}}, mag_a_in} : {{XLEN{1'b0}}, mag_b_in};
          opnd     <= funct3[2] ? mag_b_in : mag_a_in;
        end
        ST_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
          if (last) result <= result_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign we_out    = done & (rd_out != 5'd0);
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with a per-cycle compare,
// plus directed vectors carrying hand-computed results and latency checks.
module tb_muldiv_unit;
  import riscv_m_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, done, we_out;
  state_t      dbg_state;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .we_out    (we_out),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] model_calc(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ps;
    logic        [63:0] ua, ub, pu;
    int                 sa32, sb32;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    sa32 = a;
    sb32 = b;
    ps   = '0;
    pu   = '0;
    case (f)
      F3_MUL:    begin ps = sa * sb; return ps[31:0]; end
      F3_MULH:   begin ps = sa * sb; return ps[63:32]; end
      F3_MULHSU: begin ps = sa * $signed(ub); return ps[63:32]; end
      F3_MULHU:  begin pu = ua * ub; return pu[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa32 / sb32);
      end
      F3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa32 % sb32);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Model: accept tracking, 33-cycle busy window, result/rd held registers
  int          m_cnt    = 0;
  logic [31:0] m_result = '0;
  logic [4:0]  m_rd     = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt    = 0;
      m_result = '0;
      m_rd     = '0;
      exp_q.delete();
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 1 && exp_q.size() > 0) m_result = exp_q.pop_front();
    end else if (start) begin
      exp_q.push_back(model_calc(funct3, op_a, op_b));
      m_rd  = rd_in;
      m_cnt = 33;
    end
  end

  always @(negedge clk) begin
    if (checking && rst) begin
      check("cyc_busy",   {31'b0, busy},   {31'b0, m_cnt > 0});
      check("cyc_done",   {31'b0, done},   {31'b0, m_cnt == 1});
      check("cyc_we_out", {31'b0, we_out}, {31'b0, (m_cnt == 1) && (m_rd != 5'd0)});
      check("cyc_result", result,          m_result);
      check("cyc_rd_out", {27'b0, rd_out}, {27'b0, m_rd});
    end
  end

  // mode 0: plain; 1: extra start pulse while running; 2: operands changed after accept
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_lit,
                        input string name, input int mode);
    int k;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (mode == 2) begin
      op_a  = $urandom;
      op_b  = $urandom;
      rd_in = 5'($urandom_range(0, 31));
    end
    k = 1;
    while (!done && k < 60) begin
      if (mode == 1 && k == 5) begin
        start  = 1'b1;
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({name, "_done"},   {31'b0, done},   32'd1);
    check({name, "_lat"},    32'(k),          32'd33);
    check({name, "_result"}, result,          exp_lit);
    check({name, "_rd"},     {27'b0, rd_out}, {27'b0, rd});
    check({name, "_we"},     {31'b0, we_out}, {31'b0, rd != 5'd0});
    @(negedge clk);
    check({name, "_idle"},   {31'b0, busy},   32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",   {31'b0, busy},   32'd0);
    check("rst_done",   {31'b0, done},   32'd0);
    check("rst_we",     {31'b0, we_out}, 32'd0);
    check("rst_result", result,          32'd0);
    check("rst_rd",     {27'b0, rd_out}, 32'd0);
    check("rst_state",  {30'b0, dbg_state}, {30'b0, ST_IDLE});
    rst = 1'b1;
    checking = 1'b1;

    run_op(F3_MUL,    32'd7,          32'd6,          5'd5,  32'd42,         "mul_7x6",      0);
    run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE,  "mulhu_max",    0);
    run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0000,  "mulh_m1",      0);
    run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,  "mulhsu_m1x2",  0);
    run_op(F3_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd4,  32'h8000_0000,  "mulhsu_min",   0);
    run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  "div_m7_2",     0);
    run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF,  "rem_m7_2",     0);
    run_op(F3_DIV,    32'd7,          32'hFFFF_FFFE,  5'd8,  32'hFFFF_FFFD,  "div_7_m2",     0);
    run_op(F3_DIV,    32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd9,  32'd14,         "div_m100_m7",  0);
    run_op(F3_REM,    32'hFFFF_FF9C,  32'd7,          5'd10, 32'hFFFF_FFFE,  "rem_m100_7",   0);
    run_op(F3_DIVU,   32'd100,        32'd7,          5'd11, 32'd14,         "divu_100_7",   0);
    run_op(F3_REMU,   32'd100,        32'd7,          5'd12, 32'd2,          "remu_100_7",   0);
    run_op(F3_DIVU,   32'h1234,       32'd0,          5'd13, 32'hFFFF_FFFF,  "divu_by0",     0);
    run_op(F3_REM,    32'h1234,       32'd0,          5'd14, 32'h1234,       "rem_by0",      0);
    run_op(F3_DIV,    32'hFFFF_FFF9,  32'd0,          5'd15, 32'hFFFF_FFFF,  "div_neg_by0",  0);
    run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000,  "div_ovf",      0);
    run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'd0,          "rem_ovf",      0);
    run_op(F3_MUL,    32'd1000,       32'd1000,       5'd18, 32'd1000000,    "mul_ign_start", 1);
    run_op(F3_DIVU,   32'd1000,       32'd3,          5'd19, 32'd333,        "divu_op_chg",  2);

    // Abort mid-run: reset must clear outputs at once, with no done afterwards
    @(negedge clk);
    funct3 = F3_MUL; op_a = 32'd123; op_b = 32'd456; rd_in = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy",   {31'b0, busy},   32'd0);
    check("abort_done",   {31'b0, done},   32'd0);
    check("abort_result", result,          32'd0);
    check("abort_we",     {31'b0, we_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", {31'b0, done | busy}, 32'd0);

    run_op(F3_MUL,    32'd3,          32'd5,          5'd21, 32'd15,         "mul_3x5",      0);
    run_op(F3_MUL,    32'd3,          32'd5,          5'd0,  32'd15,         "mul_x0",       0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
